mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one synchronous word-wide RAM between three requesters: host loader (port 0), core data port (port 1) and core instruction fetch (port 2). It sits between the core/loader and the unified program/data RAM, serialising requests one at a time with a req/gnt/done handshake. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
- ADDR_W, 12: RAM word-address width; the RAM holds 2^ADDR_W 32-bit words.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  3  per-port request; bit n = port n.
- req_we  input  3  per-port write flag: 1 = write, 0 = read.
- req_addr  input  96  per-port byte address; port n at [32n+31:32n].
- req_wdata  input  96  per-port write data; port n at [32n+31:32n].
- gnt  output  3  one-hot, one-cycle pulse: port's command has been captured.
- done  output  3  one-hot, one-cycle pulse: transaction complete; for reads `rdata` is valid.
- rdata  output  32  read data; valid only while the matching `done` bit is high; holds its value otherwise.
- busy  output  1  high in ISSUE and RESP.
- mem_en  output  1  RAM access enable.
- mem_we  output  1  RAM write enable; qualified by `mem_en`.
- mem_addr  output  ADDR_W  RAM word address = req_addr[ADDR_W+1:2] of the winner.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data; valid the cycle after `mem_en` with `mem_we`=0.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any `req` bit is high, pick the winner, latch its we/addr/wdata, set `gnt[winner]`, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` (all registered), then go to ISSUE. If no `req` bit is high, stay in IDLE.
- ISSUE: `gnt` and `mem_en` drop at the next edge.
  - Write: set `done[winner]` and go to IDLE.
  - Read: go to RESP.
- RESP: capture `mem_rdata` into `rdata`, set `done[winner]`, go to IDLE.
- `req` is sampled only in IDLE. While a transaction is in progress, requests are ignored and not queued.
- A requester holds `req`, `req_we`, `req_addr` and `req_wdata` stable until it sees `gnt`. If `req` is still high at an IDLE edge, it is a new transaction.
- Address bits [1:0] and bits above ADDR_W+1 are ignored. There is no alignment error.
- No byte enables: every access is a full 32-bit word.
- Reset, including mid-transaction, clears the following to 0: gnt, done, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata. FSM returns to IDLE, any in-flight read response is discarded, and the RR pointer is set to last-winner = 2.

## Timing
- Request seen high in IDLE at cycle 0:
  - Read: `gnt` and `mem_en` high in cycle 1, `done` and `rdata` in cycle 3.
  - Write: `gnt` and `mem_en` high in cycle 1, RAM written at end of cycle 1, `done` in cycle 2.
- The `done` cycle is an IDLE cycle, so a new grant can appear in the following cycle.
- Throughput: one read per 3 cycles, one write per 2 cycles.
- `gnt` and `done` are never high on the same port in the same cycle.
- At most one `gnt` bit and one `done` bit are high in any cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. Priority starts at the port after the last winner (last=2 → order 0,1,2; last=0 → order 1,2,0). The last-winner pointer updates on every grant.
- Undefined: fixed priority, port 0 > port 1 > port 2. The pointer logic is not built.

## Test plan
- Single write then read, port 1 (write addr 0x0000_0010, data 0xDEAD_BEEF; then read same addr):
  - `gnt[1]` in cycle 1 of each transaction, `mem_addr`=4.
  - Write `done[1]` in cycle 2.
  - Read `done[1]` in cycle 3 with `rdata`=0xDEAD_BEEF.
- All three `req` high continuously, reads:
  - Fixed priority: grants 0,0,0,...
  - MEM_ARB_ROUND_ROBIN_EN: grants 0,1,2,0,1,2, spaced 3 cycles apart.
- `req[2]` raised while a port-0 write is in ISSUE: no `gnt[2]` until the IDLE cycle that carries `done[0]`; `gnt[2]` on the next cycle.
- Address 0x0000_4003 with ADDR_W=12: `mem_addr`=0x000. Bits [1:0] and bit 14 are ignored.
- `rst_n` low during RESP of a read:
  - All outputs 0 on the next cycle, no `done` issued.
  - After release, `req[1]` is granted normally in cycle 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between three requesters.
//   Latency: request sampled in IDLE -> gnt/mem_en +1 cycle; write done +2, read done/rdata +3.
//   Backpressure: requests are seen only in IDLE; a requester holds req until its gnt, nothing is queued.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req/req_we           per-port request and write flag (bit n = port n)
//   req_addr/req_wdata   per-port byte address / write data, port n at [32n+31:32n]
//   gnt/done             one-hot single-cycle pulses: command captured / transaction complete
//   rdata                read result, valid with done, held otherwise
//   busy                 high while a transaction is in flight
//   mem_*                RAM command (en, we, word address, wdata) and read data return
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority 0 > 1 > 2.
module mem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        req_we,
    input  logic [95:0]       req_addr,
    input  logic [95:0]       req_wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        done,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic [1:0]  win;
    logic        win_we;

    logic [1:0]  sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0]  last;

    // Port that sits at position i of the search order starting after 'last'.
    function automatic logic [1:0] port_at(input logic [1:0] l, input int i);
        int v;
        v = (int'(l) + 1 + i) % 3;
        return v[1:0];
    endfunction

    // Scan from lowest priority to highest so the highest-priority hit wins.
    always_comb begin
        sel = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req[port_at(last, i)]) sel = port_at(last, i);
        end
    end
`else
    always_comb begin
        if (req[0])      sel = 2'd0;
        else if (req[1]) sel = 2'd1;
        else             sel = 2'd2;
    end
`endif

    always_comb begin
        case (sel)
            2'd0: begin
                sel_we    = req_we[0];
                sel_addr  = req_addr[31:0];
                sel_wdata = req_wdata[31:0];
            end
            2'd1: begin
                sel_we    = req_we[1];
                sel_addr  = req_addr[63:32];
                sel_wdata = req_wdata[63:32];
            end
            default: begin
                sel_we    = req_we[2];
                sel_addr  = req_addr[95:64];
                sel_wdata = req_wdata[95:64];
            end
        endcase
    end

    // Byte-offset bits and bits above the RAM size are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= 2'd0;
            win_we    <= 1'b0;
            gnt       <= 3'b000;
            done      <= 3'b000;
            rdata     <= 32'd0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last      <= 2'd2;
`endif
        end else begin
            // Pulses default low; address/data hold their last command.
            gnt    <= 3'b000;
            done   <= 3'b000;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= 3'b001 << sel;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr[ADDR_W+1:2];
                        mem_wdata <= sel_wdata;
                        win       <= sel;
                        win_we    <= sel_we;
                        busy      <= 1'b1;
                        state     <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last      <= sel;
`endif
                    end
                end
                ISSUE: begin
                    // A write lands in the RAM at this edge, so it completes now.
                    if (win_we) begin
                        done  <= 3'b001 << win;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    rdata <= mem_rdata;
                    done  <= 3'b001 << win;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model.
//   Latency: model predicts grant/done cycles per transaction from the request time.
//   Backpressure: requesters hold req until they see their grant.
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        req;
    logic [2:0]        req_we;
    logic [95:0]       req_addr;
    logic [95:0]       req_wdata;
    logic [2:0]        gnt;
    logic [2:0]        done;
    logic [31:0]       rdata;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM attached to the arbiter.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one transaction at a time, described by its grant and done cycles.
    logic [31:0]       shadow [DEPTH];
    int                next_free;
    int                g_cyc = -1;
    int                d_cyc = -1;
    int                t_port;
    bit                t_rd;
    logic [31:0]       t_data;
    logic [31:0]       exp_rdata;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_we;
    logic [31:0]       exp_wdata;
    int                last = 2;
    int                gq[$];
    int                gcq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 3; i++) begin
            int p;
            p = (last + 1 + i) % 3;
            if (r[p]) return p;
        end
`else
        for (int i = 0; i < 3; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    // Advance one cycle: predict what the coming edge does, then compare the new cycle.
    task automatic tick();
        logic [2:0]  eg, ed;
        logic [31:0] a;
        bit          rst_edge;
        int          p;
        rst_edge = !rst_n;
        if (rst_edge) begin
            g_cyc = -1; d_cyc = -1; next_free = cyc + 1; last = 2;
            exp_rdata = 32'd0; exp_addr = '0; exp_wdata = 32'd0; exp_we = 1'b0;
        end else if (cyc >= next_free && req != 3'b000) begin
            p         = pick(req);
            last      = p;
            a         = req_addr[32*p +: 32];
            g_cyc     = cyc + 1;
            t_port    = p;
            t_rd      = !req_we[p];
            exp_addr  = a[ADDR_W+1:2];
            exp_we    = req_we[p];
            exp_wdata = req_wdata[32*p +: 32];
            if (t_rd) begin
                d_cyc  = cyc + 3;
                t_data = shadow[exp_addr];
            end else begin
                d_cyc  = cyc + 2;
                shadow[exp_addr] = exp_wdata;
            end
            next_free = d_cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        eg = (cyc == g_cyc) ? (3'b001 << t_port) : 3'b000;
        ed = (cyc == d_cyc) ? (3'b001 << t_port) : 3'b000;
        if (cyc == d_cyc && t_rd) exp_rdata = t_data;
        check("gnt", {29'd0, gnt}, {29'd0, eg});
        check("done", {29'd0, done}, {29'd0, ed});
        check("busy", {31'd0, busy}, {31'd0, (g_cyc >= 0 && cyc >= g_cyc && cyc < d_cyc)});
        check("mem_en", {31'd0, mem_en}, {31'd0, (cyc == g_cyc)});
        check("rdata", rdata, exp_rdata);
        check("mem_addr", {20'd0, mem_addr}, {20'd0, exp_addr});
        check("mem_wdata", mem_wdata, exp_wdata);
        if (cyc == g_cyc) check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (rst_edge)     check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                gq.push_back(i);
                gcq.push_back(cyc);
            end
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        req[p]              = 1'b1;
        req_we[p]           = we;
        req_addr[32*p +: 32]  = a;
        req_wdata[32*p +: 32] = d;
    endtask

    task automatic clr_req(input int p);
        req[p] = 1'b0;
    endtask

    // Directed single transaction from an idle arbiter, with latency checks.
    task automatic txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                       output logic [ADDR_W-1:0] oa, output logic [31:0] od);
        int c0, gc, dc;
        c0 = cyc; gc = -1; dc = -1; oa = '0; od = 32'd0;
        set_req(p, we, a, d);
        for (int i = 0; i < 8 && gc < 0; i++) begin
            tick();
            if (gnt[p]) begin
                gc = cyc;
                oa = mem_addr;
                clr_req(p);
            end
        end
        for (int i = 0; i < 8 && dc < 0 && gc >= 0; i++) begin
            tick();
            if (done[p]) begin
                dc = cyc;
                od = rdata;
            end
        end
        clr_req(p);
        check("txn_gnt_lat", gc - c0, 32'd1);
        check("txn_done_lat", dc - c0, we ? 32'd2 : 32'd3);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_C003) | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    logic [ADDR_W-1:0] oa;
    logic [31:0]       od;
    int                exp_seq [6];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        rst_n = 1'b0; req = 3'b000; req_we = 3'b000; req_addr = '0; req_wdata = '0;
        next_free = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Port 1 write then read back.
        txn(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, oa, od);
        check("wr_addr", {20'd0, oa}, 32'd4);
        txn(1, 1'b0, 32'h0000_0010, 32'd0, oa, od);
        check("rd_addr", {20'd0, oa}, 32'd4);
        check("rd_data", od, 32'hDEAD_BEEF);

        // Offset bits and bit 14 are ignored: 0x4003 aliases word 0.
        txn(2, 1'b1, 32'h0000_4003, 32'h1234_5678, oa, od);
        check("alias_addr", {20'd0, oa}, 32'd0);
        txn(0, 1'b0, 32'h0000_0000, 32'd0, oa, od);
        check("alias_data", od, 32'h1234_5678);

        // req[2] raised while a port-0 write is in ISSUE.
        set_req(0, 1'b1, 32'h0000_0020, 32'hCAFE_0001);
        tick();
        check("iss_gnt0", {29'd0, gnt}, 32'd1);
        clr_req(0);
        set_req(2, 1'b0, 32'h0000_0020, 32'd0);
        tick();
        check("iss_done0", {29'd0, done}, 32'd1);
        check("iss_no_gnt2", {29'd0, gnt}, 32'd0);
        tick();
        check("iss_gnt2", {29'd0, gnt}, 32'd4);
        clr_req(2);
        tick();
        tick();
        check("iss_rdata2", rdata, 32'hCAFE_0001);
        tick();

        // All three reading continuously, starting from the reset pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b0, 32'h0000_0100, 32'd0);
        set_req(1, 1'b0, 32'h0000_0104, 32'd0);
        set_req(2, 1'b0, 32'h0000_0108, 32'd0);
        gq.delete();
        gcq.delete();
        for (int i = 0; i < 18; i++) tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 0, 1, 2};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        check("seq_count", {31'd0, (gq.size() >= 6)}, 32'd1);
        if (gq.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("seq_port", gq[i], exp_seq[i]);
            for (int i = 1; i < 6; i++) check("seq_space", gcq[i] - gcq[i-1], 32'd3);
        end
        req = 3'b000;
        for (int i = 0; i < 4; i++) tick();

        // Reset during RESP of a read.
        set_req(1, 1'b0, 32'h0000_0010, 32'd0);
        tick();
        clr_req(1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_done", {29'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        tick();
        check("rst_no_late_done", {29'd0, done}, 32'd0);
        txn(1, 1'b0, 32'h0000_0010, 32'd0, oa, od);
        check("post_rst_data", od, 32'hDEAD_BEEF);

        // Random traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int p = 0; p < 3; p++) begin
                if (!req[p] && $urandom_range(0, 3) == 0)
                    set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            tick();
            for (int p = 0; p < 3; p++) if (gnt[p]) clr_req(p);
        end
        rst_n = 1'b1;
        req = 3'b000;
        for (int i = 0; i < 5; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
